// File: rtl/upb_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// upb_sched_pkg : state type, index width and RAM address packing -- rev 1.0
// ---------------------------------------------------------------------------
package upb_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam int NCOEF_DEF = 6;
  localparam int IDXW      = 3;
  localparam int ADDR_MAXW = 9;

  // Widest supported address (64 channels); callers truncate to their AW.
  function automatic logic [ADDR_MAXW-1:0] pack_addr(
    input logic [ADDR_MAXW-IDXW-1:0] ch,
    input logic [IDXW-1:0]           idx
  );
    return {ch, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/upb_sched_chsel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// upb_sched_chsel : lowest enabled channel, or next enabled above i_ch -- rev 1.0
// ---------------------------------------------------------------------------
module upb_sched_chsel #(
  parameter int NCH = 32,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_en,
  input  logic [CHW-1:0] i_ch,
  input  logic           i_first,
  output logic [CHW-1:0] o_ch,
  output logic           o_found
);

  // Scanning downward lets the lowest qualifying channel win.
  always_comb begin
    o_ch    = '0;
    o_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_en[i] && (i_first || (i > int'(i_ch)))) begin
        o_ch    = CHW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/upb_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// upb_sched : per-frame scheduler time-sharing one UPB across channels -- rev 1.0
// ---------------------------------------------------------------------------
module upb_sched
  import upb_sched_pkg::*;
#(
  parameter int NCH     = 32,
  parameter int NCOEF   = NCOEF_DEF,
  parameter int BW      = 16,
  parameter int TIMEOUT = 15,
  parameter int CHW     = $clog2(NCH),
  parameter int AW      = CHW + 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic [NCH-1:0]  ch_en,
  input  logic            err_clr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [BW-1:0]   mem_wdata,
  input  logic [BW-1:0]   mem_rdata,
  output logic            upb_start,
  output logic [CHW-1:0]  upb_ch,
  output logic [2:0]      upb_idx,
  output logic [BW-1:0]   upb_bn,
  input  logic            upb_done,
  input  logic [BW-1:0]   upb_bnp,
  output logic            busy,
  output logic            frame_done,
  output logic            err_timeout,
  output logic            err_overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [NCH-1:0]  r_en;
  logic            r_go;
  logic [CHW-1:0]  r_ch;
  logic [IDXW-1:0] r_idx;
  logic [BW-1:0]   r_bn;
  logic [BW-1:0]   r_bnp;
  logic [TW-1:0]   r_timer;
  logic            r_err_to;
  logic            r_err_ov;

  logic [CHW-1:0]  w_sel_ch;
  logic            w_found;
  logic            w_last_idx;
  logic            w_tmo;
  logic            w_advance;
  logic            w_adv_rd;
  logic            w_ov_set;
  logic [AW-1:0]   w_addr;
  logic            w_job;

  upb_sched_chsel #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_chsel (
    .i_en    (r_en),
    .i_ch    (r_ch),
    .i_first (r_state == S_IDLE),
    .o_ch    (w_sel_ch),
    .o_found (w_found)
  );

  assign w_last_idx = (r_idx == IDXW'(NCOEF - 1));
  // Timeout fires in the WAIT cycle where the timer would reach TIMEOUT,
  // so a done arriving in that same cycle still wins.
  assign w_tmo      = (r_state == S_WAIT) && !upb_done && (r_timer == TW'(TIMEOUT - 1));
  assign w_advance  = (r_state == S_WR) || w_tmo;
  assign w_adv_rd   = !w_last_idx || w_found;
  assign w_ov_set   = frame_start && (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_go && !frame_start) w_next = w_found ? S_RD : S_FIN;
      S_RD:    w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (upb_done)   w_next = S_WR;
        else if (w_tmo) w_next = w_adv_rd ? S_RD : S_FIN;
      end
      S_WR:    w_next = w_adv_rd ? S_RD : S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= '0;
      r_go     <= 1'b0;
      r_ch     <= '0;
      r_idx    <= '0;
      r_bn     <= '0;
      r_bnp    <= '0;
      r_timer  <= '0;
      r_err_to <= 1'b0;
      r_err_ov <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (frame_start) begin
          r_en <= ch_en;
          r_go <= 1'b1;
        end else if (r_go) begin
          r_go  <= 1'b0;
          r_ch  <= w_sel_ch;
          r_idx <= '0;
        end
      end
      if (r_state == S_ISSUE) begin
        r_bn    <= mem_rdata;
        r_timer <= '0;
      end
      if (r_state == S_WAIT) begin
        if (upb_done) r_bnp   <= upb_bnp;
        else          r_timer <= r_timer + TW'(1);
      end
      if (w_advance) begin
        if (!w_last_idx) begin
          r_idx <= r_idx + IDXW'(1);
        end else if (w_found) begin
          r_ch  <= w_sel_ch;
          r_idx <= '0;
        end
      end
      // A set event in the same cycle as err_clr keeps the flag set.
      if (w_tmo)        r_err_to <= 1'b1;
      else if (err_clr) r_err_to <= 1'b0;
      if (w_ov_set)     r_err_ov <= 1'b1;
      else if (err_clr) r_err_ov <= 1'b0;
    end
  end

  assign w_addr      = AW'(pack_addr((ADDR_MAXW - IDXW)'(r_ch), r_idx));
  assign w_job       = (r_state == S_ISSUE) || (r_state == S_WAIT);

  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_FIN);
  assign mem_rd      = (r_state == S_RD);
  assign mem_wr      = (r_state == S_WR);
  assign mem_addr    = (mem_rd || mem_wr) ? w_addr : '0;
  assign mem_wdata   = mem_wr ? r_bnp : '0;
  assign upb_start   = (r_state == S_ISSUE);
  assign upb_ch      = w_job ? r_ch : '0;
  assign upb_idx     = w_job ? r_idx : '0;
  assign upb_bn      = (r_state == S_ISSUE) ? mem_rdata :
                       (r_state == S_WAIT)  ? r_bn      : '0;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;

endmodule
`default_nettype wire

// File: tb/tb_upb_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_upb_sched : scoreboard bench for upb_sched with RAM and UPB models -- rev 1.0
// ---------------------------------------------------------------------------
module tb_upb_sched;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int AW  = 5;
  localparam int BW  = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           frame_start = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic           err_clr = 1'b0;
  logic           mem_rd, mem_wr;
  logic [AW-1:0]  mem_addr;
  logic [BW-1:0]  mem_wdata;
  logic [BW-1:0]  mem_rdata;
  logic           upb_start;
  logic [CHW-1:0] upb_ch;
  logic [2:0]     upb_idx;
  logic [BW-1:0]  upb_bn;
  logic           upb_done;
  logic [BW-1:0]  upb_bnp;
  logic           busy, frame_done, err_timeout, err_overrun;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] ram [0:31];
  logic [BW-1:0] exp_mem [0:31];
  logic          ram_load = 1'b1;
  int            hold_addr = -1;
  wr_t           exp_q [$];

  int            rd_cnt, wr_cnt, st_cnt, busy_cnt;
  logic [31:0]   rd_seen;
  logic [NCH-1:0] ch_seen;
  int            t_rd, t_fd, rd_addr0;

  upb_sched #(
    .NCH     (NCH),
    .NCOEF   (6),
    .BW      (BW),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .ch_en       (ch_en),
    .err_clr     (err_clr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .upb_start   (upb_start),
    .upb_ch      (upb_ch),
    .upb_idx     (upb_idx),
    .upb_bn      (upb_bn),
    .upb_done    (upb_done),
    .upb_bnp     (upb_bnp),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // RAM: read data one cycle after mem_rd; preloaded with its own address.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int a = 0; a < 32; a++) ram[a] <= BW'(a);
    end else begin
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
    end
  end

  // UPB: done one cycle after start with bn+1, unless the job is withheld.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      upb_done <= 1'b0;
      upb_bnp  <= '0;
    end else begin
      upb_done <= upb_start && (int'({upb_ch, upb_idx}) != hold_addr);
      upb_bnp  <= upb_bn + 16'd1;
    end
  end

  task automatic run_frame(input logic [NCH-1:0] mask, input int hold,
                           input int ov_at, input logic ov_clr);
    wr_t e;
    hold_addr = hold;
    rd_cnt = 0; wr_cnt = 0; st_cnt = 0; busy_cnt = 0;
    rd_seen = '0; ch_seen = '0;
    t_rd = -1; t_fd = -1; rd_addr0 = -1;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        for (int i = 0; i < 6; i++) begin
          if (c * 8 + i != hold) begin
            e.addr = AW'(c * 8 + i);
            e.data = exp_mem[c * 8 + i] + 16'd1;
            exp_q.push_back(e);
            exp_mem[c * 8 + i] = e.data;
          end
        end
      end
    end
    @(negedge clk);
    ch_en = mask;
    frame_start = 1'b1;
    for (int n = 1; n < 3000 && t_fd < 0; n++) begin
      @(negedge clk);
      frame_start = (n == ov_at);
      err_clr = ov_clr && (n == ov_at);
      if (n == ov_at) ch_en = '0;
      if (busy) busy_cnt++;
      if (mem_rd) begin
        rd_cnt++;
        rd_seen[mem_addr] = 1'b1;
        if (t_rd < 0) begin
          t_rd = n;
          rd_addr0 = int'(mem_addr);
        end
      end
      if (upb_start) begin
        st_cnt++;
        ch_seen[upb_ch] = 1'b1;
      end
      if (mem_wr) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%0d data=%0h", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
            failures++;
            $display("FAIL wr_data got addr=%0d data=%0h exp addr=%0d data=%0h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
      if (frame_done) t_fd = n;
    end
    frame_start = 1'b0;
    err_clr = 1'b0;
    checks++;
    if (t_fd < 0) begin
      failures++;
      $display("FAIL frame_done_timeout got=none exp=pulse");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_rd || mem_wr || upb_start) wr_cnt += 100;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wr_missing got=%0d outstanding exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) exp_mem[a] = BW'(a);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, mem_rd, mem_wr, mem_addr, mem_wdata, upb_start, upb_ch,
         upb_idx, upb_bn, err_timeout, err_overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b rd=%b wr=%b start=%b exp all 0",
               busy, mem_rd, mem_wr, upb_start);
    end
    ram_load = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_full_pass();
    run_frame(4'hF, -1, 0, 1'b0);
    checks++;
    if (wr_cnt != 24) begin
      failures++;
      $display("FAIL full_wr_count got=%0d exp=24", wr_cnt);
    end
    checks++;
    if (rd_seen !== 32'h3F3F3F3F) begin
      failures++;
      $display("FAIL full_rd_set got=%h exp=3f3f3f3f", rd_seen);
    end
    // Cycles counted from the first RD through the frame_done cycle inclusive.
    checks++;
    if (t_fd - t_rd + 1 != 97) begin
      failures++;
      $display("FAIL full_latency got=%0d exp=97", t_fd - t_rd + 1);
    end
    checks++;
    if ({err_timeout, err_overrun} !== 2'b00) begin
      failures++;
      $display("FAIL full_errs got=%b%b exp=00", err_timeout, err_overrun);
    end
  endtask

  task automatic test_sparse();
    run_frame(4'b0101, -1, 0, 1'b0);
    checks++;
    if (wr_cnt != 12 || st_cnt != 12) begin
      failures++;
      $display("FAIL sparse_jobs got wr=%0d start=%0d exp=12", wr_cnt, st_cnt);
    end
    checks++;
    if (rd_seen !== 32'h003F003F) begin
      failures++;
      $display("FAIL sparse_rd_set got=%h exp=003f003f", rd_seen);
    end
    checks++;
    if (ch_seen !== 4'b0101) begin
      failures++;
      $display("FAIL sparse_upb_ch got=%b exp=0101", ch_seen);
    end
  endtask

  task automatic test_empty();
    run_frame(4'h0, -1, 0, 1'b0);
    checks++;
    if (t_fd != 2) begin
      failures++;
      $display("FAIL empty_latency got=%0d exp=2", t_fd);
    end
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0 || st_cnt != 0) begin
      failures++;
      $display("FAIL empty_activity got rd=%0d wr=%0d start=%0d exp=0", rd_cnt, wr_cnt, st_cnt);
    end
    checks++;
    if (busy_cnt != 1) begin
      failures++;
      $display("FAIL empty_busy got=%0d exp=1", busy_cnt);
    end
  endtask

  task automatic test_timeout();
    run_frame(4'hF, 11, 0, 1'b0);
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL tmo_flag got=%b exp=1", err_timeout);
    end
    checks++;
    if (wr_cnt != 23 || rd_seen !== 32'h3F3F3F3F) begin
      failures++;
      $display("FAIL tmo_jobs got wr=%0d rd=%h exp wr=23 rd=3f3f3f3f", wr_cnt, rd_seen);
    end
    // Timed-out job spends RD + ISSUE + 15 WAIT instead of 4 cycles.
    checks++;
    if (t_fd - t_rd + 1 != 110) begin
      failures++;
      $display("FAIL tmo_latency got=%0d exp=110", t_fd - t_rd + 1);
    end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got=%b exp=0", err_timeout);
    end
  endtask

  task automatic test_overrun();
    run_frame(4'hF, -1, 30, 1'b0);
    checks++;
    if (err_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got=%b exp=1", err_overrun);
    end
    checks++;
    if (wr_cnt != 24 || t_fd - t_rd + 1 != 97) begin
      failures++;
      $display("FAIL ovr_pass got wr=%0d lat=%0d exp wr=24 lat=97", wr_cnt, t_fd - t_rd + 1);
    end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++;
    if ({err_timeout, err_overrun} !== 2'b00) begin
      failures++;
      $display("FAIL ovr_clear got=%b%b exp=00", err_timeout, err_overrun);
    end
    run_frame(4'hF, -1, 40, 1'b1);
    checks++;
    if (err_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins got=%b exp=1", err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    hold_addr = 0;
    @(negedge clk);
    ch_en = 4'hF;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || upb_start !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_state got busy=%b start=%b rd=%b exp 1,0,0", busy, upb_start, mem_rd);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, frame_done, mem_rd, mem_wr, mem_addr, mem_wdata, upb_start, upb_ch,
         upb_idx, upb_bn, err_timeout, err_overrun} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got busy=%b wr=%b ch=%0d bn=%h exp all 0",
               busy, mem_wr, upb_ch, upb_bn);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_wr) wr_seen++;
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_wr || busy) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      failures++;
      $display("FAIL mid_reset_activity got=%0d exp=0", wr_seen);
    end
    run_frame(4'hF, -1, 0, 1'b0);
    checks++;
    if (rd_addr0 != 0 || t_fd - t_rd + 1 != 97 || wr_cnt != 24) begin
      failures++;
      $display("FAIL mid_restart got addr0=%0d lat=%0d wr=%0d exp 0,97,24",
               rd_addr0, t_fd - t_rd + 1, wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_sparse();
    test_empty();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/upb_sched.md
Name: upb_sched

Overview:
- Time-shares the single UPB (update predictor coefficient B) instance across all codec channels.
- Once per frame it walks every enabled channel and coefficients b1..b6 in order. For each coefficient it:
  - reads the coefficient from coefficient RAM,
  - launches UPB with a start/done handshake,
  - writes the updated value back.
- Sits between the frame sequencer, the coefficient RAM and the UPB datapath.

Parameters:
- NCH, 32, number of channels (power of two, 2..64)
- NCOEF, 6, coefficients per channel (1..8)
- BW, 16, coefficient width
- TIMEOUT, 15, maximum WAIT cycles before a UPB job is abandoned
- CHW, $clog2(NCH), channel index width (derived)
- AW, CHW+3, RAM address width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; begins a frame pass
- ch_en  in  NCH  per-channel enable; sampled on an accepted frame_start
- err_clr  in  1  clears the sticky error flags
- mem_rd  out  1  RAM read strobe
- mem_wr  out  1  RAM write strobe
- mem_addr  out  AW  RAM address = {ch, idx[2:0]}
- mem_wdata  out  BW  updated coefficient
- mem_rdata  in  BW  read data, valid the cycle after mem_rd
- upb_start  out  1  one-cycle job launch
- upb_ch  out  CHW  channel of the current job
- upb_idx  out  3  coefficient index 0..NCOEF-1
- upb_bn  out  BW  coefficient operand to UPB
- upb_done  in  1  job complete; upb_bnp valid in the same cycle
- upb_bnp  in  BW  updated coefficient from UPB
- busy  out  1  high while a pass is in progress
- frame_done  out  1  one-cycle pulse at the end of a pass
- err_timeout  out  1  sticky: a UPB job timed out
- err_overrun  out  1  sticky: frame_start arrived while not IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). While reset is high:
  - all outputs are 0;
  - state is IDLE;
  - the ch/idx/timer registers are 0.
- Reset mid-pass aborts immediately. No RAM write is issued.
- States: IDLE, RD, ISSUE, WAIT, WR, FIN.
- IDLE, busy=0:
  - frame_start latches ch_en into en_q.
  - If en_q is nonzero: ch = lowest enabled channel, idx=0, go to RD.
  - If en_q is zero: go to FIN. frame_done pulses the next cycle with no RAM or UPB activity.
- RD: mem_rd=1, mem_addr={ch,idx}. Go to ISSUE.
- ISSUE:
  - Capture mem_rdata into the bn register.
  - upb_start=1 for exactly one cycle, with upb_ch/upb_idx/upb_bn valid.
  - Clear the timer. Go to WAIT.
- WAIT:
  - upb_ch/idx/bn are held stable.
  - upb_done=1: capture upb_bnp, go to WR.
  - Otherwise the timer increments. When timer==TIMEOUT: set err_timeout, skip the write, advance.
- WR:
  - mem_wr=1, mem_addr={ch,idx}, mem_wdata=captured bnp, for one cycle.
  - Then advance.
- Advance:
  - If idx<NCOEF-1: idx+1, go to RD.
  - Else if a higher enabled channel exists in en_q: idx=0, ch = next enabled channel, go to RD.
  - Else go to FIN.
- FIN: frame_done=1 for one cycle. Go to IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - Minimum 4 cycles per coefficient (RD, ISSUE, WAIT with done the cycle after start, WR).
  - Full pass with all channels enabled, 1-cycle UPB: 4·NCOEF·NCH + 1 cycles from the first RD to the frame_done pulse.
- Boundary rules:
  - upb_done outside WAIT is ignored.
  - upb_done in the same cycle that the timer reaches TIMEOUT counts as done (no error).
  - frame_start outside IDLE (including the FIN cycle) sets err_overrun. It is otherwise ignored; the current pass is neither restarted nor changed.
  - Changes to ch_en mid-pass have no effect.
  - err_clr clears both sticky flags. If a set event occurs in the same cycle, set wins.
  - Channel NCH-1 is the last candidate; there is no wrap-around back to channel 0 within a pass.

Decomposition:
- Package upb_sched_pkg holds:
  - state enum type,
  - NCOEF default,
  - IDXW=3,
  - address-packing function {ch,idx}.
- Sub-module upb_sched_chsel: combinational priority finder. Given en_q and the current ch, it returns the first enabled channel (in IDLE) or the next enabled channel greater than ch, plus a found flag. It is instantiated once.
- Everything else is one always_ff FSM plus its output decode.

Test Plan:
- NCH=4, ch_en=4'hF; UPB model returns bn+1 with done 1 cycle after start; RAM preloaded with addr value.
  - Exactly 24 writes, to addresses 0..5, 8..13, 16..21, 24..29, in that order.
  - Each write has wdata = read value + 1.
  - frame_done pulses 97 cycles after the first mem_rd.
- ch_en=4'b0101:
  - Only addresses 0..5 and 16..21 are read and written (12 jobs).
  - upb_ch takes only the values 0 and 2.
- ch_en=0, frame_start:
  - No mem_rd, mem_wr or upb_start activity.
  - frame_done pulses 2 cycles after frame_start; busy is high for 1 cycle.
- UPB model withholds done for the job ch1/idx3 (TIMEOUT=15):
  - After 15 WAIT cycles, err_timeout=1.
  - No write to address 11.
  - The pass continues with ch1/idx4 and completes normally.
- frame_start pulsed mid-pass:
  - err_overrun=1; the pass is unchanged.
  - err_clr then returns both flags to 0; err_clr coincident with a new overrun leaves err_overrun=1.
- reset asserted during WAIT:
  - All outputs are 0 in the same cycle, with no mem_wr.
  - After release, a new frame_start restarts at ch0/idx0.
